// File: rtl/pc_redirect_unit.sv
// Program-counter stage: sequential/branch/jump selection, stall hold with a one-deep
// redirect capture, and a multi-cycle IF/ID flush pulse. Define PCRU_BNE_EN to add bne_i.
module pc_redirect_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR   = '0,
  parameter int unsigned      INC          = 4,
  parameter int unsigned      FLUSH_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             equal_i,
`ifdef PCRU_BNE_EN
  input  logic             bne_i,
`endif
  input  logic [WIDTH-1:0] branch_addr_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_addr_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             flush_o,
  output logic             pending_o
);

  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES);

  logic             taken;
  logic             redirect;
  logic [WIDTH-1:0] target;
  logic             flush_load;

  logic [WIDTH-1:0] pc_q;
  logic             pending_q;
  logic [WIDTH-1:0] pend_addr_q;
  logic [3:0]       flush_cnt_q;

  always_comb begin
`ifdef PCRU_BNE_EN
    taken = branch_i & (equal_i ^ bne_i);
`else
    taken = branch_i & equal_i;
`endif
    redirect   = jump_i | taken;
    target     = jump_i ? jump_addr_i : branch_addr_i;
    // A captured redirect always wins over live redirect inputs on release.
    flush_load = ~stall_i & (pending_q | redirect);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_ADDR;
    end else if (!stall_i) begin
      if (pending_q)
        pc_q <= pend_addr_q;
      else if (redirect)
        pc_q <= target;
      else
        pc_q <= pc_q + INC_W;
    end
  end

  // First redirect seen during a stall is held; later ones are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q   <= 1'b0;
      pend_addr_q <= '0;
    end else if (stall_i) begin
      if (redirect && !pending_q) begin
        pending_q   <= 1'b1;
        pend_addr_q <= target;
      end
    end else begin
      pending_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      flush_cnt_q <= 4'd0;
    else if (flush_load)
      flush_cnt_q <= FLUSH_LOAD;
    else if (flush_cnt_q != 4'd0)
      flush_cnt_q <= flush_cnt_q - 4'd1;
  end

  assign pc_o      = pc_q;
  assign pending_o = pending_q;
  assign flush_o   = (flush_cnt_q != 4'd0);

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: two instances (32-bit/flush 1 and
// 8-bit/flush 2/reset 0xF0) driven in lockstep and compared against a reference model.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst, stall, branch, equal, jump;
`ifdef PCRU_BNE_EN
  logic        bne;
`endif
  logic [31:0] baddr, jaddr;

  logic [31:0] pc0;
  logic        flush0, pend0;
  logic [7:0]  pc1;
  logic        flush1, pend1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_redirect_unit #(.WIDTH(32), .RESET_ADDR(32'h0), .INC(4), .FLUSH_CYCLES(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .branch_i(branch), .equal_i(equal),
`ifdef PCRU_BNE_EN
    .bne_i(bne),
`endif
    .branch_addr_i(baddr), .jump_i(jump), .jump_addr_i(jaddr),
    .pc_o(pc0), .flush_o(flush0), .pending_o(pend0)
  );

  pc_redirect_unit #(.WIDTH(8), .RESET_ADDR(8'hF0), .INC(4), .FLUSH_CYCLES(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .branch_i(branch), .equal_i(equal),
`ifdef PCRU_BNE_EN
    .bne_i(bne),
`endif
    .branch_addr_i(baddr[7:0]), .jump_i(jump), .jump_addr_i(jaddr[7:0]),
    .pc_o(pc1), .flush_o(flush1), .pending_o(pend1)
  );

  // Reference model: index 0 mirrors dut0, index 1 mirrors dut1.
  logic [31:0] m_pc[2];
  logic [31:0] m_paddr[2];
  bit          m_pend[2];
  int          m_flush[2];

  function automatic logic [31:0] mask_of(int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  function automatic logic [31:0] reset_of(int k);
    return (k == 0) ? 32'h0 : 32'hF0;
  endfunction

  function automatic int flush_len_of(int k);
    return (k == 0) ? 1 : 2;
  endfunction

  task automatic model_step();
    bit          tk, redir;
    logic [31:0] tgt;
`ifdef PCRU_BNE_EN
    tk = branch && (equal != bne);
`else
    tk = branch && equal;
`endif
    redir = jump || tk;
    for (int k = 0; k < 2; k++) begin
      tgt = (jump ? jaddr : baddr) & mask_of(k);
      if (rst) begin
        m_pc[k]    = reset_of(k);
        m_pend[k]  = 0;
        m_paddr[k] = 0;
        m_flush[k] = 0;
      end else if (!stall && (m_pend[k] || redir)) begin
        m_pc[k]    = m_pend[k] ? m_paddr[k] : tgt;
        m_pend[k]  = 0;
        m_flush[k] = flush_len_of(k);
      end else begin
        if (!stall)
          m_pc[k] = (m_pc[k] + 32'd4) & mask_of(k);
        else if (redir && !m_pend[k]) begin
          m_pend[k]  = 1;
          m_paddr[k] = tgt;
        end
        if (m_flush[k] > 0) m_flush[k] = m_flush[k] - 1;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc0",      pc0,           m_pc[0]);
    chk("flush0",   32'(flush0),   32'(m_flush[0] != 0));
    chk("pending0", 32'(pend0),    32'(m_pend[0]));
    chk("pc1",      32'(pc1),      m_pc[1]);
    chk("flush1",   32'(flush1),   32'(m_flush[1] != 0));
    chk("pending1", 32'(pend1),    32'(m_pend[1]));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_paddr[k] = 0; m_pend[k] = 0; m_flush[k] = 0;
    end
    rst = 1; stall = 0; branch = 0; equal = 0; jump = 0;
    baddr = 0; jaddr = 0;
`ifdef PCRU_BNE_EN
    bne = 0;
`endif

    // reset then free-run
    cycle(); cycle();
    chk("rst_pc0", pc0, 32'h0);
    chk("rst_pc1", 32'(pc1), 32'hF0);
    chk("rst_flush0", 32'(flush0), 32'h0);
    rst = 0;
    cycle(); cycle(); cycle();
    chk("run_pc0", pc0, 32'h0000_000C);
    cycle();

    // BEQ taken from 0x10
    branch = 1; equal = 1; baddr = 32'h40;
    cycle();
    chk("beq_pc", pc0, 32'h40);
    chk("beq_flush", 32'(flush0), 32'h1);
    branch = 0;
    cycle();
    chk("beq_flush_end", 32'(flush0), 32'h0);
    chk("beq_flush1_len", 32'(flush1), 32'h1);

    // BEQ not taken
    branch = 1; equal = 0; baddr = 32'h80;
    cycle();
    chk("bnt_pc", pc0, 32'h48);
    chk("bnt_flush", 32'(flush0), 32'h0);

    // jump beats taken branch
    jump = 1; jaddr = 32'h100; branch = 1; equal = 1; baddr = 32'h40;
    cycle();
    chk("jmp_prio_pc", pc0, 32'h100);
    jump = 0; branch = 0;

    // redirects during a 3-cycle stall
    stall = 1; jump = 1; jaddr = 32'h200;
    cycle();
    chk("stall_hold1", pc0, 32'h100);
    chk("stall_pend1", 32'(pend0), 32'h1);
    jump = 0; branch = 1; equal = 1; baddr = 32'h80;
    cycle();
    chk("stall_hold2", pc0, 32'h100);
    branch = 0;
    cycle();
    stall = 0;
    cycle();
    chk("release_pc", pc0, 32'h200);
    chk("release_pend", 32'(pend0), 32'h0);
    chk("release_flush", 32'(flush0), 32'h1);

    // 8-bit wrap: 0xFC + 4 -> 0x00
    jump = 1; jaddr = 32'h1FC;
    cycle();
    jump = 0;
    cycle();
    chk("wrap_pc1", 32'(pc1), 32'h0);
    chk("wrap_pc0", pc0, 32'h200);

    // reset while pending and flushing
    jump = 1; jaddr = 32'h300;
    cycle();
    stall = 1; jaddr = 32'h3F0;
    cycle();
    chk("pre_rst_pend1", 32'(pend1), 32'h1);
    chk("pre_rst_flush1", 32'(flush1), 32'h1);
    rst = 1;
    cycle();
    chk("mid_rst_pc1", 32'(pc1), 32'hF0);
    chk("mid_rst_pend1", 32'(pend1), 32'h0);
    chk("mid_rst_flush1", 32'(flush1), 32'h0);
    rst = 0; stall = 0; jump = 0;
    cycle();

`ifdef PCRU_BNE_EN
    branch = 1; bne = 1; equal = 0; baddr = 32'h60;
    cycle();
    chk("bne_pc", pc0, 32'h60);
    chk("bne_flush_c1", 32'(flush1), 32'h1);
    branch = 0; bne = 0;
    cycle();
    chk("bne_flush_c2", 32'(flush1), 32'h1);
    cycle();
    chk("bne_flush_c3", 32'(flush1), 32'h0);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 39) == 0);
      stall  = ($urandom_range(0, 2) == 0);
      branch = ($urandom_range(0, 2) == 0);
      equal  = $urandom_range(0, 1) == 1;
      jump   = ($urandom_range(0, 4) == 0);
      baddr  = $urandom & 32'hFFFF_FFFC;
      jaddr  = $urandom & 32'hFFFF_FFFC;
`ifdef PCRU_BNE_EN
      bne    = $urandom_range(0, 1) == 1;
`endif
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
